// File: rtl/serial_writer_pkg.sv
// Shared types and constants for the serial byte writer: FSM states, default
// widths, the power-on memory table and the even-parity helper.
package serial_writer_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_e;

  // Word i holds 2**(i+1)-1, a thermometer pattern that is easy to spot on readout.
  localparam logic [DEFAULT_DATA_WIDTH-1:0] DEFAULT_TABLE [1 << DEFAULT_ADDR_WIDTH] = '{
    8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF
  };

  // True when data plus its trailing parity bit carry an even number of ones.
  function automatic logic even_parity_ok(input logic [DEFAULT_DATA_WIDTH:0] frame);
    return ~(^frame);
  endfunction

endpackage

// File: rtl/byte_memory_8x8.sv
// Small word memory: synchronous write, synchronous clear that reloads the
// default table, asynchronous read.
module byte_memory_8x8
  import serial_writer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the clear-reload makes every word a resettable flop, so this storage
  // cannot map onto a RAM macro; that is accepted for an 8x8 array.
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= DEFAULT_TABLE[i];
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/serial_byte_writer.sv
// Bit-serial (LSB first) to parallel writer into an 8x8 byte memory.
// Define PARITY_CHECK_EN to append an even-parity bit to each transfer.
module serial_byte_writer
  import serial_writer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  startWrite,
  input  logic [ADDR_WIDTH-1:0] writeAddress,
  input  logic                  serialIn,
  input  logic                  serialValid,
  input  logic [ADDR_WIDTH-1:0] readAddress,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  busy,
  output logic                  writeDone,
  output logic                  parityError
);

`ifdef PARITY_CHECK_EN
  localparam int SHIFT_W = DATA_WIDTH + 1;
`else
  localparam int SHIFT_W = DATA_WIDTH;
`endif
  localparam logic [3:0] LAST_BIT = 4'(SHIFT_W - 1);

  state_e                state_q;
  logic [3:0]            bit_cnt_q;
  logic [SHIFT_W-1:0]    shift_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  mem_we;

`ifdef PARITY_CHECK_EN
  logic perr_q;
  logic frame_ok;

  assign frame_ok    = even_parity_ok(shift_q);
  assign mem_we      = (state_q == COMMIT) && frame_ok;
  assign parityError = perr_q;
`else
  assign mem_we      = (state_q == COMMIT);
  assign parityError = 1'b0;
`endif

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef PARITY_CHECK_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (startWrite) begin
            addr_q    <= writeAddress;
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
`ifdef PARITY_CHECK_EN
            perr_q    <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          if (serialValid) begin
            for (int i = 0; i < SHIFT_W; i++) begin
              if (bit_cnt_q == 4'(i)) shift_q[i] <= serialIn;
            end
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == LAST_BIT) state_q <= COMMIT;
          end
        end
        COMMIT: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
`ifdef PARITY_CHECK_EN
          if (!frame_ok) perr_q <= 1'b1;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign writeDone = done_q;

  byte_memory_8x8 #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clock  (clock),
    .clear  (clear),
    .we_i   (mem_we),
    .waddr_i(addr_q),
    .wdata_i(shift_q[DATA_WIDTH-1:0]),
    .raddr_i(readAddress),
    .rdata_o(dataOut)
  );

endmodule

// File: tb/tb_serial_byte_writer.sv
// Directed bench for serial_byte_writer: table of write transfers plus
// hand-written sequences for clear, back-to-back and parity corner cases.
module tb_serial_byte_writer;

`ifdef PARITY_CHECK_EN
  localparam int NBITS = 9;
`else
  localparam int NBITS = 8;
`endif
  // Samples with busy high for an unstalled transfer: acceptance edge plus one per bit.
  localparam int LAT = NBITS + 1;

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic       startWrite = 1'b0;
  logic [2:0] writeAddress = '0;
  logic       serialIn = 1'b0;
  logic       serialValid = 1'b0;
  logic [2:0] readAddress = '0;
  logic [7:0] dataOut;
  logic       busy;
  logic       writeDone;
  logic       parityError;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] model [8];

`ifdef PARITY_CHECK_EN
  bit par_flip = 1'b0;
`endif

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
    int         stall_pos;
    int         stall_len;
    bit         poke;
    int         exp_busy;
    int         exp_done_at;
  } vec_t;

  vec_t vecs [4];

  serial_byte_writer dut (
    .clock       (clock),
    .clear       (clear),
    .startWrite  (startWrite),
    .writeAddress(writeAddress),
    .serialIn    (serialIn),
    .serialValid (serialValid),
    .readAddress (readAddress),
    .dataOut     (dataOut),
    .busy        (busy),
    .writeDone   (writeDone),
    .parityError (parityError)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_defaults();
    model[0] = 8'h01; model[1] = 8'h03; model[2] = 8'h07; model[3] = 8'h0F;
    model[4] = 8'h1F; model[5] = 8'h3F; model[6] = 8'h7F; model[7] = 8'hFF;
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 8; i++) begin
      readAddress = 3'(i);
      #1;
      check($sformatf("%s mem[%0d]", tag, i), {24'd0, dataOut}, {24'd0, model[i]});
    end
  endtask

  function automatic logic [8:0] make_frame(input logic [7:0] d);
    logic [8:0] f;
    f = {^d, d};
`ifdef PARITY_CHECK_EN
    f[8] = f[8] ^ par_flip;
`endif
    return f;
  endfunction

  task automatic send_bits(input logic [7:0] d, input int count);
    logic [8:0] f;
    f = make_frame(d);
    for (int b = 0; b < count; b++) begin
      serialValid = 1'b1;
      serialIn    = f[b];
      tick();
    end
    serialValid = 1'b0;
  endtask

  // One transfer with optional stall; counts busy samples and locates the done pulse.
  task automatic do_write(input logic [2:0] a, input logic [7:0] d, input int stall_pos,
                          input int stall_len, input bit poke,
                          output int busy_n, output int done_at, output int done_n);
    logic [8:0] f;
    int idx;
    f = make_frame(d);
    busy_n = 0; done_at = -1; done_n = 0; idx = 0;
    startWrite = 1'b1; writeAddress = a;
    tick();
    startWrite = 1'b0; writeAddress = ~a;
    if (busy) busy_n++;
    if (writeDone) begin done_n++; if (done_at < 0) done_at = idx; end
    idx++;
    for (int b = 0; b < NBITS + 3; b++) begin
      if (b == stall_pos) begin
        for (int s = 0; s < stall_len; s++) begin
          serialValid = 1'b0;
          if (poke) begin startWrite = 1'b1; writeAddress = 3'd7; end
          tick();
          startWrite = 1'b0;
          if (busy) busy_n++;
          if (writeDone) begin done_n++; if (done_at < 0) done_at = idx; end
          idx++;
        end
      end
      serialValid = (b < NBITS);
      serialIn    = (b < NBITS) ? f[b] : 1'b0;
      tick();
      serialValid = 1'b0;
      if (busy) busy_n++;
      if (writeDone) begin done_n++; if (done_at < 0) done_at = idx; end
      idx++;
    end
  endtask

  initial begin
    int busy_n, done_at, done_n;

    vecs[0] = '{addr: 3'd5, data: 8'hA5, stall_pos: -1, stall_len: 0, poke: 1'b0,
                exp_busy: LAT,     exp_done_at: LAT};
    vecs[1] = '{addr: 3'd2, data: 8'hA5, stall_pos: 4,  stall_len: 3, poke: 1'b1,
                exp_busy: LAT + 3, exp_done_at: LAT + 3};
    vecs[2] = '{addr: 3'd6, data: 8'h00, stall_pos: 0,  stall_len: 1, poke: 1'b0,
                exp_busy: LAT + 1, exp_done_at: LAT + 1};
    vecs[3] = '{addr: 3'd0, data: 8'hFE, stall_pos: 7,  stall_len: 2, poke: 1'b0,
                exp_busy: LAT + 2, exp_done_at: LAT + 2};

    // Reset
    clear = 1'b1;
    tick(); tick();
    clear = 1'b0;
    load_defaults();
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset writeDone", {31'd0, writeDone}, 32'd0);
    check("reset parityError", {31'd0, parityError}, 32'd0);
    check_mem("reset");

    // Table-driven transfers
    for (int v = 0; v < 4; v++) begin
      do_write(vecs[v].addr, vecs[v].data, vecs[v].stall_pos, vecs[v].stall_len,
               vecs[v].poke, busy_n, done_at, done_n);
      check($sformatf("vec%0d busy cycles", v), busy_n, vecs[v].exp_busy);
      check($sformatf("vec%0d done edge", v), done_at, vecs[v].exp_done_at);
      check($sformatf("vec%0d done count", v), done_n, 1);
      check($sformatf("vec%0d parityError", v), {31'd0, parityError}, 32'd0);
      model[vecs[v].addr] = vecs[v].data;
      check_mem($sformatf("vec%0d", v));
    end

    // Clear in the middle of a transfer: partial byte dropped, table reloaded
    startWrite = 1'b1; writeAddress = 3'd3;
    tick();
    startWrite = 1'b0;
    send_bits(8'h3C, 4);
    readAddress = 3'd3;
    #1;
    check("mid-shift read old", {24'd0, dataOut}, 32'h0F);
    check("mid-shift busy", {31'd0, busy}, 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("after clear busy", {31'd0, busy}, 32'd0);
    send_bits(8'hFF, 4);
    tick();
    check("after clear no done", {31'd0, writeDone}, 32'd0);
    load_defaults();
    check_mem("after clear");
    do_write(3'd3, 8'h3C, -1, 0, 1'b0, busy_n, done_at, done_n);
    check("rewrite done count", done_n, 1);
    model[3] = 8'h3C;
    check_mem("rewrite");

    // Back-to-back: second start accepted in the writeDone cycle
    startWrite = 1'b1; writeAddress = 3'd0;
    tick();
    startWrite = 1'b0;
    send_bits(8'h11, NBITS);
    check("b2b commit busy", {31'd0, busy}, 32'd1);
    tick();
    check("b2b first done", {31'd0, writeDone}, 32'd1);
    check("b2b first idle", {31'd0, busy}, 32'd0);
    startWrite = 1'b1; writeAddress = 3'd1;
    tick();
    startWrite = 1'b0;
    check("b2b second accepted", {31'd0, busy}, 32'd1);
    check("b2b done self-clears", {31'd0, writeDone}, 32'd0);
    readAddress = 3'd0;
    #1;
    check("b2b readback addr0", {24'd0, dataOut}, 32'h11);
    send_bits(8'h22, NBITS);
    tick();
    check("b2b second done", {31'd0, writeDone}, 32'd1);
    model[0] = 8'h11;
    model[1] = 8'h22;
    check_mem("b2b");

`ifdef PARITY_CHECK_EN
    par_flip = 1'b0;
    do_write(3'd4, 8'h03, -1, 0, 1'b0, busy_n, done_at, done_n);
    check("parity ok done edge", done_at, 10);
    check("parity ok error", {31'd0, parityError}, 32'd0);
    model[4] = 8'h03;
    par_flip = 1'b1;
    do_write(3'd6, 8'h03, -1, 0, 1'b0, busy_n, done_at, done_n);
    check("parity bad done count", done_n, 1);
    check("parity bad error", {31'd0, parityError}, 32'd1);
    tick(); tick();
    check("parity error holds", {31'd0, parityError}, 32'd1);
    check_mem("parity");
    par_flip = 1'b0;
    startWrite = 1'b1; writeAddress = 3'd7;
    tick();
    startWrite = 1'b0;
    check("parity error cleared on start", {31'd0, parityError}, 32'd0);
    send_bits(8'h5A, NBITS);
    tick();
    check("parity follow-up done", {31'd0, writeDone}, 32'd1);
    model[7] = 8'h5A;
    check_mem("parity follow-up");
`else
    check("parityError tied low", {31'd0, parityError}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
